// File: rtl/trace_pkg.sv
// Shared types and width helpers for the trace window buffer.
// The entry width depends on whether TRACE_TIMESTAMP_EN is defined in the top.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int DROP_W = 16;

  // Channel index field width; a single channel still carries a 1-bit tag.
  function automatic int chw_f(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  function automatic int ew_f(input int fpay, input int nch, input int ts_w, input bit ts_en);
    return (ts_en ? ts_w : 0) + chw_f(nch) + fpay;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// Read data register resets to zero and holds its value between reads.
module trace_ram #(
  parameter int DW = 34,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto a RAM macro; only the
  // output register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_window_buffer.sv
// Multi-channel trace capture into a circular RAM with arm/trigger/post window.
// Define TRACE_TIMESTAMP_EN to prepend a free-running cycle timestamp to each entry.
module trace_window_buffer
  import trace_pkg::*;
#(
  parameter int Fpay     = 32,
  parameter int NCH      = 4,
  parameter int TB_Depth = 512,
  parameter int TS_W     = 16,
  localparam int AW      = $clog2(TB_Depth),
  localparam int CHW     = chw_f(NCH),
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN   = 1'b1,
`else
  localparam bit TS_EN   = 1'b0,
`endif
  localparam int EW      = ew_f(Fpay, NCH, TS_W, TS_EN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH*Fpay-1:0] trace,
  input  logic [NCH-1:0]      trace_vld,
  input  logic [NCH-1:0]      ch_mask,
  input  logic                arm,
  input  logic                trigger,
  input  logic [AW:0]         post_cnt,
  input  logic                rd,
  output logic [EW-1:0]       dout,
  output logic                dout_vld,
  output logic [1:0]          state,
  output logic [AW:0]         count,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(TB_Depth);

  trace_state_e      state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     remain_q, remain_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              dout_vld_q;

  logic [NCH-1:0]    req;
  logic              any_req, multi_req, capturing;
  logic [CHW-1:0]    win_idx;
  logic [Fpay-1:0]   win_pay;
  logic [CW-1:0]     post_clamp;
  logic              wr_en, rd_en;
  logic [EW-1:0]     wr_data;

  assign req       = trace_vld & ch_mask;
  assign any_req   = |req;
  assign multi_req = |(req & (req - NCH'(1)));
  assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign post_clamp = (post_cnt > DEPTH) ? DEPTH : post_cnt;

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    win_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) win_idx = CHW'(i);
    end
  end

  assign win_pay = trace[int'(win_idx)*Fpay +: Fpay];

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  assign wr_data = {ts_q, win_idx, win_pay};
`else
  assign wr_data = {win_idx, win_pay};
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    remain_d = remain_q;
    drop_d   = drop_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_ARMED: begin
        if (trigger) begin
          if (post_clamp == '0) begin
            state_d = ST_DONE;
          end else begin
            // The trigger-cycle sample, if present, is the first post entry.
            wr_en    = any_req;
            remain_d = post_clamp - CW'(any_req);
            state_d  = (remain_d == '0) ? ST_DONE : ST_POST;
          end
        end else begin
          wr_en = any_req;
        end
      end
      ST_POST: begin
        wr_en = any_req;
        if (any_req) begin
          remain_d = remain_q - CW'(1);
          if (remain_q == CW'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rd && (count_q != '0)) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - CW'(1);
        end
      end
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != DEPTH) count_d = count_q + CW'(1);
    end

    if (capturing && multi_req && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

    // Oldest held entry sits count entries behind the write pointer.
    if ((state_q != ST_DONE) && (state_d == ST_DONE)) rd_ptr_d = wr_ptr_d - count_d[AW-1:0];

    // Arm overrides everything except a read already accepted this cycle.
    if (arm) begin
      state_d  = ST_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      remain_d = '0;
      drop_d   = '0;
      wr_en    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      remain_q   <= '0;
      drop_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      remain_q   <= remain_d;
      drop_q     <= drop_d;
      dout_vld_q <= rd_en;
    end
  end

  trace_ram #(
    .DW (EW),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (dout)
  );

  assign dout_vld = dout_vld_q;
  assign state    = state_q;
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trace_window_buffer.sv
// Scoreboard bench for trace_window_buffer (NCH=4, TB_Depth=8): directed
// captures push expected entries; a monitor pops them on every dout_vld.
module tb_trace_window_buffer;
  import trace_pkg::*;

  localparam int FPAY  = 32;
  localparam int N_CH  = 4;
  localparam int DEPTH = 8;
  localparam int TSW   = 16;
  localparam int AWB   = $clog2(DEPTH);
  localparam int CHWB  = chw_f(N_CH);
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TSEN  = 1'b1;
`else
  localparam bit TSEN  = 1'b0;
`endif
  localparam int EWB   = ew_f(FPAY, N_CH, TSW, TSEN);
  localparam int LOWW  = CHWB + FPAY;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_CH*FPAY-1:0] trace;
  logic [N_CH-1:0]      trace_vld;
  logic [N_CH-1:0]      ch_mask;
  logic                 arm, trigger, rd;
  logic [AWB:0]         post_cnt;
  logic [EWB-1:0]       dout;
  logic                 dout_vld;
  logic [1:0]           state;
  logic [AWB:0]         count;
  logic [15:0]          drop_cnt;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int vld_seen = 0;
  logic [63:0] exp_q [$];
  logic [15:0] ts_got [$];

  trace_window_buffer #(
    .Fpay(FPAY), .NCH(N_CH), .TB_Depth(DEPTH), .TS_W(TSW)
  ) dut (
    .clk(clk), .reset(reset), .trace(trace), .trace_vld(trace_vld),
    .ch_mask(ch_mask), .arm(arm), .trigger(trigger), .post_cnt(post_cnt),
    .rd(rd), .dout(dout), .dout_vld(dout_vld), .state(state),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int ch, input logic [31:0] pay);
    trace = '0;
    trace[ch*FPAY +: FPAY] = pay;
    trace_vld = N_CH'(1) << ch;
  endtask

  task automatic idle_in();
    trace = '0;
    trace_vld = '0;
  endtask

  task automatic expect_entry(input int ch, input logic [31:0] pay);
    logic [1:0] c;
    c = 2'(ch);
    exp_q.push_back(64'({c, pay}));
    pushed++;
  endtask

  task automatic read_n(input int n);
    rd = 1'b1;
    for (int i = 0; i < n; i++) step();
    rd = 1'b0;
  endtask

  // Monitor: consumes one expected entry per dout_vld pulse.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (dout_vld === 1'b1) begin
        vld_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_dout_vld", 64'(dout[LOWW-1:0]), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("dout_entry", 64'(dout[LOWW-1:0]), e);
        end
`ifdef TRACE_TIMESTAMP_EN
        ts_got.push_back(dout[EWB-1 -: TSW]);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset = 1'b0; idle_in(); ch_mask = 4'hF;
    arm = 0; trigger = 0; rd = 0; post_cnt = '0;
    #23;
    check("rst_state", 64'(state), 0);
    check("rst_count", 64'(count), 0);
    check("rst_drop", 64'(drop_cnt), 0);
    check("rst_dout_vld", 64'(dout_vld), 0);
    check("rst_dout", 64'(dout), 0);
    reset = 1'b1;
    step();

    // Trigger outside ARMED is ignored.
    trigger = 1; post_cnt = 2; step(); trigger = 0;
    check("idle_trigger_ignored", 64'(state), 0);

    // Basic window: 3 pre-trigger + trigger sample + 1 post sample.
    arm = 1; step(); arm = 0;
    check("armed_state", 64'(state), 1);
    sample(1, 32'h11); step();
    sample(1, 32'h12); step();
    sample(1, 32'h13); step();
    check("armed_count", 64'(count), 3);
    sample(1, 32'h14); trigger = 1; post_cnt = 2; step(); trigger = 0;
    check("post_state", 64'(state), 2);
    sample(1, 32'h15); step(); idle_in();
    check("basic_done_state", 64'(state), 3);
    check("basic_done_count", 64'(count), 5);
    for (int i = 0; i < 5; i++) expect_entry(1, 32'h11 + 32'(i));
    rd = 1; step();
    check("read_latency_vld", 64'(dout_vld), 1);
    read_n(4);
    step();
    check("basic_count_drained", 64'(count), 0);
    check("dout_holds", 64'(dout[LOWW-1:0]), 64'h1_0000_0015);
    check("dout_vld_clears", 64'(dout_vld), 0);

    // Wrap: 24 writes into 8 entries keep the newest 8.
    arm = 1; step(); arm = 0;
    for (int i = 0; i < 20; i++) begin sample(0, 32'(i)); step(); end
    check("wrap_count_sat", 64'(count), 8);
    sample(0, 32'd20); trigger = 1; post_cnt = 4; step(); trigger = 0;
    for (int i = 21; i < 24; i++) begin sample(0, 32'(i)); step(); end
    check("wrap_done_state", 64'(state), 3);
    sample(0, 32'd99); step(); idle_in();
    check("wrap_no_write_done", 64'(count), 8);
    for (int i = 16; i < 24; i++) expect_entry(0, 32'(i));
    read_n(8);
    step();

    // Contention: ch0 beats ch2, then masking lets ch2 through.
    arm = 1; step(); arm = 0;
    for (int k = 0; k < 3; k++) begin
      trace = '0; trace_vld = 4'b0101;
      trace[0*FPAY +: FPAY] = 32'hA0 + 32'(k);
      trace[2*FPAY +: FPAY] = 32'hC0 + 32'(k);
      step();
    end
    check("contention_drop", 64'(drop_cnt), 3);
    ch_mask = 4'b0100;
    trace[0*FPAY +: FPAY] = 32'hA3; trace[2*FPAY +: FPAY] = 32'hC3; step();
    check("masked_drop_same", 64'(drop_cnt), 3);
    trace[2*FPAY +: FPAY] = 32'hC4; trigger = 1; post_cnt = 1; step(); trigger = 0;
    idle_in(); ch_mask = 4'hF;
    check("contention_done", 64'(state), 3);
    check("contention_count", 64'(count), 5);
    for (int k = 0; k < 3; k++) expect_entry(0, 32'hA0 + 32'(k));
    expect_entry(2, 32'hC3);
    expect_entry(2, 32'hC4);
    read_n(5);
    step();

    // post_cnt = 0: trigger sample is not stored.
    arm = 1; step(); arm = 0;
    sample(3, 32'h31); step();
    sample(3, 32'h32); trigger = 1; post_cnt = 0; step(); trigger = 0; idle_in();
    check("p0_state", 64'(state), 3);
    check("p0_count", 64'(count), 1);
    // Read and arm together: the read still completes.
    expect_entry(3, 32'h31);
    rd = 1; arm = 1; step(); rd = 0; arm = 0;
    check("rd_arm_vld", 64'(dout_vld), 1);
    check("rd_arm_state", 64'(state), 1);
    check("rd_arm_count", 64'(count), 0);
    // Arm and trigger together: arm wins.
    sample(0, 32'h77); arm = 1; trigger = 1; post_cnt = 0; step();
    arm = 0; trigger = 0; idle_in();
    check("arm_trig_state", 64'(state), 1);
    trigger = 1; post_cnt = 0; step(); trigger = 0;
    check("empty_done_count", 64'(count), 0);
    step();
    seen = vld_seen;
    read_n(2); step();
    check("rd_empty_no_vld", 64'(vld_seen), 64'(seen));

    // Async reset in the middle of POST.
    arm = 1; step(); arm = 0;
    sample(0, 32'h50); step();
    sample(0, 32'h51); trigger = 1; post_cnt = 5; step(); trigger = 0;
    check("pre_reset_post", 64'(state), 2);
    #2; reset = 1'b0; #1;
    check("async_rst_state", 64'(state), 0);
    check("async_rst_count", 64'(count), 0);
    check("async_rst_vld", 64'(dout_vld), 0);
    idle_in();
    #3; reset = 1'b1;
    step();
    seen = vld_seen;
    read_n(2); step();
    check("post_rst_rd_ignored", 64'(vld_seen), 64'(seen));
    check("post_rst_idle", 64'(state), 0);

`ifdef TRACE_TIMESTAMP_EN
    arm = 1; step(); arm = 0;
    sample(0, 32'h61); step(); idle_in();
    for (int i = 0; i < 4; i++) step();
    sample(0, 32'h62); trigger = 1; post_cnt = 1; step(); trigger = 0; idle_in();
    ts_got.delete();
    expect_entry(0, 32'h61);
    expect_entry(0, 32'h62);
    read_n(2); step(); step();
    check("ts_count", 64'(ts_got.size()), 2);
    if (ts_got.size() == 2) check("ts_delta", 64'(16'(ts_got[1] - ts_got[0])), 5);
`endif

    for (int i = 0; i < 3; i++) step();
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    check("vld_pulse_total", 64'(vld_seen), 64'(pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
